// File: rtl/hex_entry_input.sv
// ---------------------------------------------------------------------------
// hex_entry_input
//
// Hex digit entry from board switches and three push buttons.
// Each button is synchronised, debounced and turned into a one-cycle
// rising-edge pulse. A two-state FSM assembles digits into a word and
// offers that word to a consumer.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   sw[3:0]      hex digit, sampled when a push is acted on
//   btn_push     raw button: shift sw into the word
//   btn_clr      raw button: clear the word
//   btn_send     raw button: offer the word to the consumer
//   ack          consumer has taken the word (looked at only while valid=1)
//   data         assembled word (drives the display)
//   digit_cnt    digits entered, saturating at WIDTH/4
//   valid        word is being offered
//   o_dbg_state  current FSM state (0 = ENTRY, 1 = OFFER)
//
// Handshake: valid rises the cycle after a send pulse and stays high until
// the first clock edge that sees ack=1. That edge clears data and
// digit_cnt and drops valid, so the word transfers on the edge where
// valid=1 and ack=1. valid is a flop output; ack reaches it only through
// the next-state logic, never combinationally.
//
// digit_cnt is four bits wide, so WIDTH is limited to 60.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// hex_entry_debounce
//
// One button channel: 2-flop synchroniser, stability debouncer and a
// registered rising-edge detector.
//
// Ports
//   clk, rst     as in the top level
//   i_btn        raw asynchronous button level
//   o_pulse      one-cycle pulse for every debounced 0->1 transition
//
// Latency from a stable-high input to o_pulse: 2 (sync) + DEB_N + 1 cycles.
// ---------------------------------------------------------------------------
module hex_entry_debounce #(
    parameter int DEB_N = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    // The counter only has to reach DEB_N-1.
    localparam int CNT_W = (DEB_N <= 2) ? 1 : $clog2(DEB_N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_N - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;

            // r_cnt holds how many consecutive cycles the synchronised
            // input has disagreed with the debounced level. The cycle that
            // would make it DEB_N flips the level instead.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            // Registered rising-edge detect; releases give no pulse.
            r_level_q <= r_level;
            r_pulse   <= r_level & ~r_level_q;
        end
    end

    assign o_pulse = r_pulse;

endmodule

module hex_entry_input #(
    parameter int WIDTH = 32,
    parameter int DEB_N = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       sw,
    input  logic             btn_push,
    input  logic             btn_clr,
    input  logic             btn_send,
    input  logic             ack,
    output logic [WIDTH-1:0] data,
    output logic [3:0]       digit_cnt,
    output logic             valid,
    output logic             o_dbg_state
);

    localparam logic [3:0] MAX_CNT = 4'(WIDTH / 4);

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [3:0]       r_digit_cnt;
    logic [3:0]       w_digit_cnt_nxt;
    logic             r_valid;
    logic             w_valid_nxt;

    logic             w_push_p;
    logic             w_clr_p;
    logic             w_send_p;

    // -----------------------------------------------------------------
    // Button conditioning
    // -----------------------------------------------------------------
    hex_entry_debounce #(.DEB_N(DEB_N)) u_deb_push (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_push),
        .o_pulse (w_push_p)
    );

    hex_entry_debounce #(.DEB_N(DEB_N)) u_deb_clr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_clr),
        .o_pulse (w_clr_p)
    );

    hex_entry_debounce #(.DEB_N(DEB_N)) u_deb_send (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_send),
        .o_pulse (w_send_p)
    );

    // -----------------------------------------------------------------
    // FSM state and datapath registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_ENTRY;
            r_data      <= '0;
            r_digit_cnt <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= w_data_nxt;
            r_digit_cnt <= w_digit_cnt_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic. In ENTRY only one pulse is acted on per cycle,
    // with clear beating send beating push. In OFFER every pulse is
    // dropped and only ack matters.
    // -----------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_data_nxt      = r_data;
        w_digit_cnt_nxt = r_digit_cnt;
        w_valid_nxt     = r_valid;

        case (r_state)
            ST_ENTRY: begin
                if (w_clr_p) begin
                    w_data_nxt      = '0;
                    w_digit_cnt_nxt = '0;
                end else if (w_send_p) begin
                    // An empty word is sent as well.
                    w_state_nxt = ST_OFFER;
                    w_valid_nxt = 1'b1;
                end else if (w_push_p) begin
                    // The top nibble falls off the end.
                    w_data_nxt = (r_data << 4) | WIDTH'(sw);
                    if (r_digit_cnt < MAX_CNT) begin
                        w_digit_cnt_nxt = r_digit_cnt + 4'd1;
                    end
                end
            end

            ST_OFFER: begin
                if (ack) begin
                    w_state_nxt     = ST_ENTRY;
                    w_data_nxt      = '0;
                    w_digit_cnt_nxt = '0;
                    w_valid_nxt     = 1'b0;
                end
            end

            default: begin
                w_state_nxt = ST_ENTRY;
            end
        endcase
    end

    assign data        = r_data;
    assign digit_cnt   = r_digit_cnt;
    assign valid       = r_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hex_entry_input.sv
// ---------------------------------------------------------------------------
// tb_hex_entry_input
//
// Randomised and directed stimulus for hex_entry_input with DEB_N=4.
// A cycle-level behavioural model turns each button's raw level history
// into action times: the level seen by the debouncer is the raw level two
// edges earlier, the debounced level follows once that has disagreed for
// DEB_N edges in a row, and a rising debounced level takes effect on the
// word two edges later. Every negative clock edge compares the DUT with the
// model. Directed scenarios add literal expectations worked out by hand.
// ---------------------------------------------------------------------------
module tb_hex_entry_input;

    localparam int WIDTH = 32;
    localparam int DEB_N = 4;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       sw = 4'h0;
    logic             btn_push = 1'b0;
    logic             btn_clr = 1'b0;
    logic             btn_send = 1'b0;
    logic             ack = 1'b0;
    logic [WIDTH-1:0] data;
    logic [3:0]       digit_cnt;
    logic             valid;
    logic             dbg_state;

    always #5 clk = ~clk;

    hex_entry_input #(.WIDTH(WIDTH), .DEB_N(DEB_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn_push    (btn_push),
        .btn_clr     (btn_clr),
        .btn_send    (btn_send),
        .ack         (ack),
        .data        (data),
        .digit_cnt   (digit_cnt),
        .valid       (valid),
        .o_dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // Button index: 0 = push, 1 = clr, 2 = send.
    bit               raw_p1 [3];  // raw level at the previous edge
    bit               raw_p2 [3];  // raw level two edges ago
    bit               deb    [3];
    int               run    [3];  // edges in a row seen level != deb
    bit               rise_p1[3];  // debounced level rose at previous edge
    bit               rise_p2[3];  // ... two edges ago
    logic [WIDTH-1:0] m_data  = '0;
    int               m_cnt   = 0;
    bit               m_valid = 1'b0;

    function automatic bit raw_now(input int b);
        case (b)
            0:       return btn_push;
            1:       return btn_clr;
            default: return btn_send;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            raw_p1[b]  = 1'b0;
            raw_p2[b]  = 1'b0;
            deb[b]     = 1'b0;
            run[b]     = 0;
            rise_p1[b] = 1'b0;
            rise_p2[b] = 1'b0;
        end
        m_data  = '0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        bit rise_now[3];
        // Word update from the actions that matured this edge.
        if (!m_valid) begin
            if (rise_p2[1]) begin
                m_data = '0;
                m_cnt  = 0;
            end else if (rise_p2[2]) begin
                m_valid = 1'b1;
            end else if (rise_p2[0]) begin
                m_data = m_data * 16 + WIDTH'(sw);
                m_cnt  = (m_cnt + 1 > WIDTH / 4) ? WIDTH / 4 : m_cnt + 1;
            end
        end else if (ack) begin
            m_data  = '0;
            m_cnt   = 0;
            m_valid = 1'b0;
        end
        // Debounced levels.
        for (int b = 0; b < 3; b++) begin
            rise_now[b] = 1'b0;
            if (raw_p2[b] != deb[b]) begin
                run[b]++;
                if (run[b] == DEB_N) begin
                    deb[b]      = raw_p2[b];
                    run[b]      = 0;
                    rise_now[b] = deb[b];
                end
            end else begin
                run[b] = 0;
            end
        end
        for (int b = 0; b < 3; b++) begin
            rise_p2[b] = rise_p1[b];
            rise_p1[b] = rise_now[b];
            raw_p2[b]  = raw_p1[b];
            raw_p1[b]  = raw_now(b);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_edge();
        end
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if (data !== m_data || digit_cnt !== 4'(m_cnt) || valid !== m_valid) begin
                errors++;
                $display("FAIL model_cmp t=%0t: data=%h cnt=%0d valid=%b, model data=%h cnt=%0d valid=%b",
                         $time, data, digit_cnt, valid, m_data, m_cnt, m_valid);
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic check_eq(input string name, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_push = v;
            1:       btn_clr  = v;
            default: btn_send = v;
        endcase
    endtask

    // Clean press: held long enough to register, then released long
    // enough for the debounced level to fall back.
    task automatic press(input int b, input logic [3:0] d);
        sw = d;
        set_btn(b, 1'b1);
        cycles(DEB_N + 6);
        set_btn(b, 1'b0);
        cycles(DEB_N + 6);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1 rst = 1'b0;
        cycles(3);
        check_eq("reset_data",  data, '0);
        check_eq("reset_cnt",   WIDTH'(digit_cnt), '0);
        check_eq("reset_valid", WIDTH'(valid), '0);
        rst = 1'b1;
        cycles(2);

        // Three digits.
        press(0, 4'h1);
        press(0, 4'h2);
        press(0, 4'h3);
        check_eq("three_data",  data, 32'h0000_0123);
        check_eq("three_cnt",   WIDTH'(digit_cnt), 32'd3);
        check_eq("three_valid", WIDTH'(valid), '0);

        // Nine digits: saturation and wrap-off.
        press(1, 4'h0);
        for (int i = 1; i <= 9; i++) press(0, 4'(i));
        check_eq("nine_data", data, 32'h2345_6789);
        check_eq("nine_cnt",  WIDTH'(digit_cnt), 32'd8);

        // Bouncing push, then held: one digit.
        press(1, 4'h0);
        sw = 4'h5;
        for (int i = 0; i < 10; i++) begin
            btn_push = ~i[0];
            cycles(2);
        end
        btn_push = 1'b1;
        cycles(DEB_N + 6);
        btn_push = 1'b0;
        cycles(DEB_N + 6);
        check_eq("bounce_cnt",  WIDTH'(digit_cnt), 32'd1);
        check_eq("bounce_data", data, 32'h0000_0005);

        // Offer 0xAB, push dropped while offered, then ack.
        press(1, 4'h0);
        press(0, 4'hA);
        press(0, 4'hB);
        press(2, 4'h0);
        check_eq("offer_valid", WIDTH'(valid), 32'd1);
        check_eq("offer_state", WIDTH'(dbg_state), 32'd1);
        press(0, 4'h7);
        check_eq("offer_frozen_data", data, 32'h0000_00AB);
        check_eq("offer_frozen_cnt",  WIDTH'(digit_cnt), 32'd2);
        ack = 1'b1;
        #1;
        check_eq("ack_not_comb", WIDTH'(valid), 32'd1);
        cycles(1);
        check_eq("ack_valid", WIDTH'(valid), '0);
        check_eq("ack_data",  data, '0);
        check_eq("ack_cnt",   WIDTH'(digit_cnt), '0);
        ack = 1'b0;
        cycles(2);

        // Clear and push in the same cycle.
        press(0, 4'h3);
        sw = 4'h6;
        btn_clr  = 1'b1;
        btn_push = 1'b1;
        cycles(DEB_N + 6);
        btn_clr  = 1'b0;
        btn_push = 1'b0;
        cycles(DEB_N + 6);
        check_eq("clr_push_data", data, '0);
        check_eq("clr_push_cnt",  WIDTH'(digit_cnt), '0);

        // Button held across reset release: one push after DEB_N+4 edges.
        sw = 4'h9;
        btn_push = 1'b1;
        rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(DEB_N + 3);
        check_eq("held_before", WIDTH'(digit_cnt), '0);
        cycles(1);
        check_eq("held_cnt",  WIDTH'(digit_cnt), 32'd1);
        check_eq("held_data", data, 32'h0000_0009);
        btn_push = 1'b0;
        cycles(DEB_N + 6);

        // Reset mid-debounce discards the pending press.
        btn_push = 1'b1;
        cycles(DEB_N);
        btn_push = 1'b0;
        do_reset();
        cycles(DEB_N + 6);
        check_eq("mid_deb_cnt", WIDTH'(digit_cnt), '0);

        // Asynchronous reset while offering.
        press(0, 4'h4);
        press(2, 4'h0);
        check_eq("pre_rst_valid", WIDTH'(valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_data",  data, '0);
        check_eq("async_cnt",   WIDTH'(digit_cnt), '0);
        check_eq("async_valid", WIDTH'(valid), '0);
        cycles(2);
        rst = 1'b1;
        cycles(2);

        // Randomised buttons, switches and acks.
        for (int it = 0; it < 250; it++) begin
            sw       = 4'($urandom_range(0, 15));
            btn_push = ($urandom_range(0, 2) == 0);
            btn_clr  = ($urandom_range(0, 6) == 0);
            btn_send = ($urandom_range(0, 5) == 0);
            ack      = ($urandom_range(0, 3) == 0);
            cycles($urandom_range(1, 2 * DEB_N + 4));
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        btn_push = 1'b0;
        btn_clr  = 1'b0;
        btn_send = 1'b0;
        ack      = 1'b0;
        cycles(3 * DEB_N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
